// File: rtl/ddr_port_arbiter_if.sv
// Core-side (I/D masters) and ram-side signal bundle around ddr_port_arbiter.
// slave = arbiter view, master = environment view (core masters plus ram wrapper).
interface ddr_port_arbiter_if #(
    parameter int ADDR_W = 29,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_read_req;
    logic              ram_write_req;
    logic              ram_read_ready;
    logic              ram_write_ready;
    logic              ram_stall;
    logic              ram_rvalid;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
               ram_read_ready, ram_write_ready, ram_stall, ram_rvalid, ram_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               ram_addr, ram_wdata, ram_read_req, ram_write_req
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
               ram_read_ready, ram_write_ready, ram_stall, ram_rvalid, ram_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               ram_addr, ram_wdata, ram_read_req, ram_write_req
    );
endinterface

// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing one DDR ram port between I-fetch and D masters, one transaction in flight.
// Optional read watchdog enabled by defining DDR_ARB_TIMEOUT_EN (adds TIMEOUT_CYCLES and timeout_err).
module ddr_port_arbiter #(
    parameter int ADDR_W         = 29,
`ifdef DDR_ARB_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 1024,
`endif
    parameter int DATA_W         = 32
) (
    input  logic clk,
    input  logic rst_n,
`ifdef DDR_ARB_TIMEOUT_EN
    output logic timeout_err,
`endif
    ddr_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_e            state_q, state_d;
    logic              last_owner_q, last_owner_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_req_q, rd_req_d;
    logic              wr_req_q, wr_req_d;
    logic              i_gnt_q, i_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              i_qual_s, d_qual_s;
    logic              grant_i_s, grant_d_s;
    logic              rsp_s, expire_s, done_s;
    logic              i_rvalid_s, d_rvalid_s;
    logic [DATA_W-1:0] rsp_data_s;

`ifdef DDR_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;

    // Watchdog: cleared while issuing so WAIT_RD starts at zero, counts every WAIT_RD cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_ISSUE) begin
            cnt_d = 16'd0;
        end else if (state_q == ST_WAIT_RD) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A real response on the expiry cycle takes priority over the timeout.
    assign expire_s    = (state_q == ST_WAIT_RD) && !bus.ram_rvalid && (cnt_q == TMO_LAST);
    assign timeout_err = expire_s;
`else
    assign expire_s = 1'b0;
`endif

    // Read completion and routing to the owning master; rdata is a same-cycle pass-through.
    always_comb begin
        rsp_s      = (state_q == ST_WAIT_RD) && bus.ram_rvalid;
        done_s     = rsp_s || expire_s;
        rsp_data_s = rsp_s ? bus.ram_rdata : {DATA_W{1'b0}};
        i_rvalid_s = done_s && (owner_q == OWN_I);
        d_rvalid_s = done_s && (owner_q == OWN_D);
        i_rdata_d  = i_rvalid_s ? rsp_data_s : i_rdata_q;
        d_rdata_d  = d_rvalid_s ? rsp_data_s : d_rdata_q;
    end

    // Request qualification, round-robin pick and FSM next state.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_req_d     = 1'b0;
        wr_req_d     = 1'b0;
        i_gnt_d      = 1'b0;
        d_gnt_d      = 1'b0;

        i_qual_s  = bus.i_req && !bus.ram_stall && bus.ram_read_ready;
        d_qual_s  = bus.d_req && !bus.ram_stall &&
                    (bus.d_we ? bus.ram_write_ready : bus.ram_read_ready);
        grant_i_s = i_qual_s && (!d_qual_s || (last_owner_q == OWN_D));
        grant_d_s = d_qual_s && !grant_i_s;

        case (state_q)
            ST_IDLE: begin
                if (grant_i_s) begin
                    owner_d      = OWN_I;
                    last_owner_d = OWN_I;
                    we_d         = 1'b0;
                    addr_d       = bus.i_addr;
                    rd_req_d     = 1'b1;
                    i_gnt_d      = 1'b1;
                    state_d      = ST_ISSUE;
                end else if (grant_d_s) begin
                    owner_d      = OWN_D;
                    last_owner_d = OWN_D;
                    we_d         = bus.d_we;
                    addr_d       = bus.d_addr;
                    wdata_d      = bus.d_wdata;
                    rd_req_d     = !bus.d_we;
                    wr_req_d     = bus.d_we;
                    d_gnt_d      = 1'b1;
                    state_d      = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = we_q ? ST_IDLE : ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                if (done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_RD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered ram/grant outputs; last_owner resets to D so I wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWN_D;
            owner_q      <= OWN_I;
            we_q         <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            wdata_q      <= {DATA_W{1'b0}};
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            i_gnt_q      <= 1'b0;
            d_gnt_q      <= 1'b0;
            i_rdata_q    <= {DATA_W{1'b0}};
            d_rdata_q    <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_req_q     <= rd_req_d;
            wr_req_q     <= wr_req_d;
            i_gnt_q      <= i_gnt_d;
            d_gnt_q      <= d_gnt_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.ram_addr      = addr_q;
    assign bus.ram_wdata     = wdata_q;
    assign bus.ram_read_req  = rd_req_q;
    assign bus.ram_write_req = wr_req_q;
    assign bus.i_gnt         = i_gnt_q;
    assign bus.d_gnt         = d_gnt_q;
    assign bus.i_rvalid      = i_rvalid_s;
    assign bus.d_rvalid      = d_rvalid_s;
    assign bus.i_rdata       = i_rdata_d;
    assign bus.d_rdata       = d_rdata_d;
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Scoreboard bench for ddr_port_arbiter: expected owner/data queued at issue, popped at read return.
module tb_ddr_port_arbiter;
    localparam int   ADDR_W = 29;
    localparam int   DATA_W = 32;
    localparam logic OWN_I  = 1'b0;
    localparam logic OWN_D  = 1'b1;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic              own_q[$];
    logic [DATA_W-1:0] data_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    logic [DATA_W-1:0] last_i, last_d;

    ddr_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef DDR_ARB_TIMEOUT_EN
    logic timeout_err;
    ddr_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(8), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .timeout_err(timeout_err), .bus(bus));
`else
    ddr_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: got still running expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic init_inputs();
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.ram_read_ready = 1'b1; bus.ram_write_ready = 1'b1;
        bus.ram_stall = 1'b0; bus.ram_rvalid = 1'b0; bus.ram_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_i = '0;
        last_d = '0;
        @(negedge clk);
    endtask

    task automatic wait_gnt(input int budget, output int cyc, output logic seen);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            seen = bus.i_gnt | bus.d_gnt;
        end
    endtask

    task automatic test_reset();
        init_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.ram_read_req, bus.ram_write_req} !== 6'b0)
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.ram_read_req, bus.ram_write_req});
        else n_pass++;
        n_checks++;
        if (bus.ram_addr !== 29'h0 || bus.ram_wdata !== 32'h0 || bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0)
            $display("FAIL reset_data: got addr=%h wdata=%h ir=%h dr=%h expected all 0",
                     bus.ram_addr, bus.ram_wdata, bus.i_rdata, bus.d_rdata);
        else n_pass++;
        rst_n = 1'b1;
        last_i = '0;
        last_d = '0;
        @(negedge clk);
        bus.ram_rdata = 32'h11112222; bus.ram_rvalid = 1'b1;
        #1;
        n_checks++;
        if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0)
            $display("FAIL stale_rvalid: got i=%b d=%b expected 0 0", bus.i_rvalid, bus.d_rvalid);
        else n_pass++;
        @(negedge clk);
        bus.ram_rvalid = 1'b0;
    endtask

    task automatic test_single_read();
        int cyc; logic seen; logic exp_own; logic [DATA_W-1:0] exp_data;
        bus.i_addr = 29'h40; bus.i_req = 1'b1;
        wait_gnt(20, cyc, seen);
        n_checks++;
        if (!seen || cyc != 1 || bus.i_gnt !== 1'b1 || bus.d_gnt !== 1'b0)
            $display("FAIL t1_gnt: got seen=%b cyc=%0d ig=%b dg=%b expected 1 1 1 0", seen, cyc, bus.i_gnt, bus.d_gnt);
        else n_pass++;
        n_checks++;
        if (bus.ram_read_req !== 1'b1 || bus.ram_write_req !== 1'b0 || bus.ram_addr !== 29'h40)
            $display("FAIL t1_issue: got rd=%b wr=%b addr=%h expected 1 0 40",
                     bus.ram_read_req, bus.ram_write_req, bus.ram_addr);
        else n_pass++;
        bus.i_req = 1'b0;
        @(negedge clk);
        bus.ram_stall = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.ram_read_req !== 1'b0 || bus.i_gnt !== 1'b0 || bus.i_rvalid !== 1'b0)
            $display("FAIL t1_wait: got rd=%b ig=%b iv=%b expected 0 0 0", bus.ram_read_req, bus.i_gnt, bus.i_rvalid);
        else n_pass++;
        own_q.push_back(OWN_I); data_q.push_back(32'hDEADBEEF);
        bus.ram_rdata = 32'hDEADBEEF; bus.ram_rvalid = 1'b1;
        #1;
        exp_own = own_q.pop_front(); exp_data = data_q.pop_front();
        n_checks++;
        if (bus.i_rvalid !== (exp_own == OWN_I) || bus.d_rvalid !== (exp_own == OWN_D) || bus.i_rdata !== exp_data)
            $display("FAIL t1_rdata: got iv=%b dv=%b ir=%h expected 1 0 %h", bus.i_rvalid, bus.d_rvalid, bus.i_rdata, exp_data);
        else n_pass++;
        last_i = exp_data;
        @(negedge clk);
        bus.ram_rvalid = 1'b0; bus.ram_stall = 1'b0;
        #1;
        n_checks++;
        if (bus.i_rvalid !== 1'b0 || bus.i_rdata !== last_i)
            $display("FAIL t1_hold: got iv=%b ir=%h expected 0 %h", bus.i_rvalid, bus.i_rdata, last_i);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int cyc; logic seen; logic exp_owner; logic exp_own; logic [DATA_W-1:0] exp_data;
        logic [ADDR_W-1:0] ia, da, exp_a; logic [DATA_W-1:0] obs, held, held_exp;
        do_reset();
        ia = 29'h100; da = 29'h200;
        bus.i_addr = ia; bus.d_addr = da; bus.d_we = 1'b0;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        exp_owner = OWN_I;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(20, cyc, seen);
            exp_a = exp_owner ? da : ia;
            n_checks++;
            if (!seen || (bus.i_gnt && bus.d_gnt) || bus.d_gnt !== exp_owner || bus.ram_addr !== exp_a)
                $display("FAIL t2_grant%0d: got ig=%b dg=%b addr=%h expected owner=%b addr=%h",
                         k, bus.i_gnt, bus.d_gnt, bus.ram_addr, exp_owner, exp_a);
            else n_pass++;
            own_q.push_back(exp_owner); data_q.push_back(32'hA5000000 | 32'(k));
            @(negedge clk);
            bus.ram_rdata = 32'hA5000000 | 32'(k); bus.ram_rvalid = 1'b1;
            #1;
            exp_own = own_q.pop_front(); exp_data = data_q.pop_front();
            n_checks++;
            if (bus.i_rvalid !== (exp_own == OWN_I) || bus.d_rvalid !== (exp_own == OWN_D))
                $display("FAIL t2_route%0d: got iv=%b dv=%b expected owner=%b", k, bus.i_rvalid, bus.d_rvalid, exp_own);
            else n_pass++;
            obs      = exp_own ? bus.d_rdata : bus.i_rdata;
            held     = exp_own ? bus.i_rdata : bus.d_rdata;
            held_exp = exp_own ? last_i : last_d;
            n_checks++;
            if (obs !== exp_data || held !== held_exp)
                $display("FAIL t2_data%0d: got owner=%h other=%h expected %h %h", k, obs, held, exp_data, held_exp);
            else n_pass++;
            if (exp_own) last_d = exp_data; else last_i = exp_data;
            @(negedge clk);
            bus.ram_rvalid = 1'b0;
            if (exp_owner) begin da = da + 29'd1; bus.d_addr = da; end
            else begin ia = ia + 29'd1; bus.i_addr = ia; end
            exp_owner = ~exp_owner;
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
    endtask

    task automatic test_write_stream();
        int cyc; logic seen; logic [ADDR_W-1:0] exp_a;
        bus.d_we = 1'b1; bus.d_wdata = 32'hDEADBEEF; bus.d_addr = 29'h0;
        addr_q.push_back(29'h0);
        bus.d_req = 1'b1;
        for (int k = 0; k < 256; k++) begin
            wait_gnt(10, cyc, seen);
            exp_a = addr_q.pop_front();
            n_checks++;
            if (!seen || bus.d_gnt !== 1'b1 || bus.ram_write_req !== 1'b1 || bus.ram_read_req !== 1'b0 ||
                bus.ram_addr !== exp_a || bus.ram_wdata !== 32'hDEADBEEF || (k > 0 && cyc != 2))
                $display("FAIL t3_write%0d: got dg=%b wr=%b addr=%h wdata=%h gap=%0d expected 1 1 %h deadbeef 2",
                         k, bus.d_gnt, bus.ram_write_req, bus.ram_addr, bus.ram_wdata, cyc, exp_a);
            else n_pass++;
            if (k < 255) begin
                bus.d_addr = 29'(4 * (k + 1));
                addr_q.push_back(29'(4 * (k + 1)));
            end else begin
                bus.d_req = 1'b0;
            end
        end
    endtask

    task automatic test_stall();
        logic bad;
        @(negedge clk);
        bus.ram_stall = 1'b1;
        bus.d_we = 1'b1; bus.d_addr = 29'h80; bus.d_wdata = 32'h12345678; bus.d_req = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.ram_read_req || bus.ram_write_req || bus.d_gnt || bus.i_gnt) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) $display("FAIL t4_stalled: got activity=%b expected 0", bad);
        else n_pass++;
        bus.ram_stall = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.d_gnt !== 1'b1 || bus.ram_write_req !== 1'b1 || bus.ram_addr !== 29'h80 || bus.ram_wdata !== 32'h12345678)
            $display("FAIL t4_release: got dg=%b wr=%b addr=%h wdata=%h expected 1 1 80 12345678",
                     bus.d_gnt, bus.ram_write_req, bus.ram_addr, bus.ram_wdata);
        else n_pass++;
        bus.d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc; logic seen; logic exp_own; logic [DATA_W-1:0] exp_data;
        bus.d_we = 1'b0; bus.i_addr = 29'h55; bus.i_req = 1'b1;
        wait_gnt(20, cyc, seen);
        n_checks++;
        if (!seen || bus.i_gnt !== 1'b1) $display("FAIL t5_gnt: got seen=%b ig=%b expected 1 1", seen, bus.i_gnt);
        else n_pass++;
        bus.i_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.ram_read_req !== 1'b0 || bus.ram_addr !== 29'h0 || bus.i_rdata !== 32'h0)
            $display("FAIL t5_in_reset: got rd=%b addr=%h ir=%h expected 0 0 0", bus.ram_read_req, bus.ram_addr, bus.i_rdata);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1; last_i = '0; last_d = '0;
        @(negedge clk);
        bus.ram_rdata = 32'h0BAD0BAD; bus.ram_rvalid = 1'b1;
        #1;
        n_checks++;
        if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.i_rdata !== 32'h0)
            $display("FAIL t5_dropped: got iv=%b dv=%b ir=%h expected 0 0 0", bus.i_rvalid, bus.d_rvalid, bus.i_rdata);
        else n_pass++;
        @(negedge clk);
        bus.ram_rvalid = 1'b0;
        bus.d_addr = 29'h66; bus.d_req = 1'b1;
        wait_gnt(20, cyc, seen);
        n_checks++;
        if (!seen || cyc != 1 || bus.d_gnt !== 1'b1 || bus.ram_read_req !== 1'b1 || bus.ram_addr !== 29'h66)
            $display("FAIL t5_next_gnt: got cyc=%0d dg=%b rd=%b addr=%h expected 1 1 1 66",
                     cyc, bus.d_gnt, bus.ram_read_req, bus.ram_addr);
        else n_pass++;
        bus.d_req = 1'b0;
        own_q.push_back(OWN_D); data_q.push_back(32'hCAFEF00D);
        @(negedge clk);
        bus.ram_rdata = 32'hCAFEF00D; bus.ram_rvalid = 1'b1;
        #1;
        exp_own = own_q.pop_front(); exp_data = data_q.pop_front();
        n_checks++;
        if (bus.d_rvalid !== (exp_own == OWN_D) || bus.i_rvalid !== (exp_own == OWN_I) ||
            bus.d_rdata !== exp_data || bus.i_rdata !== last_i)
            $display("FAIL t5_next_data: got dv=%b iv=%b dr=%h ir=%h expected 1 0 %h %h",
                     bus.d_rvalid, bus.i_rvalid, bus.d_rdata, bus.i_rdata, exp_data, last_i);
        else n_pass++;
        last_d = exp_data;
        @(negedge clk);
        bus.ram_rvalid = 1'b0;
    endtask

`ifdef DDR_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int cyc; logic seen; logic bad; logic exp_own; logic [DATA_W-1:0] exp_data;
        bus.i_addr = 29'h77; bus.i_req = 1'b1;
        wait_gnt(20, cyc, seen);
        n_checks++;
        if (!seen || bus.i_gnt !== 1'b1) $display("FAIL t6_gnt: got seen=%b ig=%b expected 1 1", seen, bus.i_gnt);
        else n_pass++;
        bus.i_req = 1'b0;
        own_q.push_back(OWN_I); data_q.push_back(32'h0);
        bad = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (bus.i_rvalid || bus.d_rvalid || timeout_err) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) $display("FAIL t6_early: got activity=%b expected 0", bad);
        else n_pass++;
        @(negedge clk);
        exp_own = own_q.pop_front(); exp_data = data_q.pop_front();
        n_checks++;
        if (bus.i_rvalid !== (exp_own == OWN_I) || bus.d_rvalid !== (exp_own == OWN_D) ||
            bus.i_rdata !== exp_data || timeout_err !== 1'b1)
            $display("FAIL t6_expiry: got iv=%b dv=%b ir=%h err=%b expected 1 0 %h 1",
                     bus.i_rvalid, bus.d_rvalid, bus.i_rdata, timeout_err, exp_data);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (timeout_err !== 1'b0 || bus.i_rvalid !== 1'b0)
            $display("FAIL t6_pulse: got err=%b iv=%b expected 0 0", timeout_err, bus.i_rvalid);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_stream();
        test_stall();
        test_reset_mid();
`ifdef DDR_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
